// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave receiver with valid/ack handshake; optional frame timeout under `SPI_RX_TIMEOUT_EN
module spi_slave_rx #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [15:0] TIMEOUT_MS = 16'd10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_1kHz,
    input  logic                  sel_aktiv,
    input  logic                  spi_cs,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cs_q, mosi_q;
    logic [2:0]            sclk_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, word;
    logic                  valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic                  cs_s, mosi_s, rise, last;

    assign cs_s   = cs_q[1];
    assign mosi_s = mosi_q[1];
    assign rise   = sclk_q[1] & ~sclk_q[2];
    assign word   = {shreg_q, mosi_s};
    assign last   = cnt_q == CW'(DATA_WIDTH - 1);

`ifdef SPI_RX_TIMEOUT_EN
    logic [2:0]  tick_q;
    logic [15:0] to_q, to_d;
    logic        tick;

    assign tick = tick_q[1] & ~tick_q[2];

    // timebase synchroniser and inactivity counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
            to_q   <= '0;
        end else begin
            tick_q <= {tick_q[1:0], clk_1kHz};
            to_q   <= to_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = clk_1kHz ^ (^TIMEOUT_MS);
`endif

    // input synchronisers and all receiver state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q    <= 2'b11;
            sclk_q  <= '0;
            mosi_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cs_q    <= {cs_q[0], spi_cs};
            sclk_q  <= {sclk_q[1:0], spi_clk};
            mosi_q  <= {mosi_q[0], spi_mosi};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    // frame FSM: a rise in the cs-release cycle is shifted before the frame closes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        valid_d = valid_q & ~data_ack;
        ovr_d   = ovr_q & ~(valid_q & data_ack);
        ferr_d  = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (!cs_s && !sel_aktiv) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
`ifdef SPI_RX_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            SHIFT: begin
                if (sel_aktiv) begin
                    state_d = IDLE;
                end else begin
                    if (rise) begin
                        shreg_d = word[DATA_WIDTH-2:0];
                        cnt_d   = last ? '0 : cnt_q + 1'b1;
                        if (last) begin
                            dout_d  = word;
                            valid_d = 1'b1;
                            ovr_d   = ovr_d | (valid_q & ~data_ack);
                        end
                    end
`ifdef SPI_RX_TIMEOUT_EN
                    to_d = rise ? '0 : to_q + 16'(tick);
                    if (!rise && tick && to_q + 16'd1 == TIMEOUT_MS) begin
                        state_d = HOLD;
                        ferr_d  = 1'b1;
                    end
`endif
                    if (cs_s) begin
                        state_d = IDLE;
                        ferr_d  = ferr_d | (cnt_d != '0);
                    end
                end
            end
            default: state_d = cs_s ? IDLE : HOLD;
        endcase
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q == SHIFT;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed checks of spi_slave_rx framing, handshake, abort and reset behaviour
module tb_spi_slave_rx;
    logic       clk = 1'b0, reset_n = 1'b0, clk_1kHz = 1'b0, sel_aktiv = 1'b0;
    logic       spi_cs = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0, data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;
    logic       v_prev = 1'b0, auto_ack = 1'b0;
    logic [7:0] vlog [0:15];
    int         n_chk = 0, n_fail = 0, ferr_hi = 0, nlog = 0, f0, l0;

    always #5 clk = ~clk;
    always #200 clk_1kHz = ~clk_1kHz;

    spi_slave_rx #(.DATA_WIDTH(8), .TIMEOUT_MS(16'd3)) dut (
        .clk(clk), .reset_n(reset_n), .clk_1kHz(clk_1kHz), .sel_aktiv(sel_aktiv),
        .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    // count frame_err high cycles and log every newly presented word
    always @(negedge clk) begin
        ferr_hi <= ferr_hi + int'(frame_err);
        v_prev  <= data_valid;
        if (data_valid && !v_prev && nlog < 16) begin
            vlog[nlog] <= data_out;
            nlog       <= nlog + 1;
        end
    end

    // consumer that acknowledges each word one cycle after it appears
    initial forever begin
        @(negedge clk);
        if (auto_ack) data_ack = data_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = v[i];
            wait_clk(5);
            spi_clk = 1'b1;
            wait_clk(5);
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] v);
        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(v, 8);
        wait_clk(5);
        spi_cs = 1'b1;
        wait_clk(10);
    endtask

    task automatic ack_once;
        data_ack = 1'b1;
        wait_clk(1);
        data_ack = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        wait_clk(3);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_clk(3);

        f0 = ferr_hi;
        spi_cs = 1'b0;
        wait_clk(5);
        check("t1_busy", busy, 1);
        send_bits(8'hA5, 8);
        wait_clk(5);
        spi_cs = 1'b1;
        wait_clk(10);
        check("t1_data", data_out, 8'hA5);
        check("t1_valid", data_valid, 1);
        check("t1_ferr", ferr_hi - f0, 0);
        check("t1_ovr", overrun, 0);
        ack_once;
        check("t1_ack", data_valid, 0);
        ack_once;
        check("t1_ack_idle_v", data_valid, 0);
        check("t1_ack_idle_o", overrun, 0);

        auto_ack = 1'b1;
        l0 = nlog;
        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        wait_clk(5);
        spi_cs = 1'b1;
        wait_clk(10);
        auto_ack = 1'b0;
        data_ack = 1'b0;
        wait_clk(2);
        check("t2_count", nlog - l0, 2);
        check("t2_w0", vlog[l0], 8'h3C);
        check("t2_w1", vlog[l0+1], 8'hC3);
        check("t2_ovr", overrun, 0);
        check("t2_valid", data_valid, 0);

        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        wait_clk(5);
        spi_cs = 1'b1;
        wait_clk(10);
        check("t3_data", data_out, 8'hC3);
        check("t3_valid", data_valid, 1);
        check("t3_ovr", overrun, 1);
        ack_once;
        check("t3_ack_v", data_valid, 0);
        check("t3_ack_o", overrun, 0);

        f0 = ferr_hi;
        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(8'hFF, 5);
        wait_clk(5);
        spi_cs = 1'b1;
        wait_clk(10);
        check("t4_ferr_pulse", ferr_hi - f0, 1);
        check("t4_valid", data_valid, 0);
        check("t4_busy", busy, 0);

        f0 = ferr_hi;
        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(8'hFF, 5);
        sel_aktiv = 1'b1;
        wait_clk(4);
        check("t4s_busy", busy, 0);
        spi_cs = 1'b1;
        wait_clk(5);
        sel_aktiv = 1'b0;
        wait_clk(5);
        check("t4s_ferr", ferr_hi - f0, 0);
        check("t4s_valid", data_valid, 0);

        frame(8'h55);
        check("t5_pre_valid", data_valid, 1);
        f0 = ferr_hi;
        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(8'hFF, 4);
        reset_n = 1'b0;
        #1;
        check("t5_rst_data", data_out, 8'h00);
        check("t5_rst_valid", data_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ovr", overrun, 0);
        spi_cs = 1'b1;
        wait_clk(1);
        reset_n = 1'b1;
        wait_clk(5);
        frame(8'h81);
        check("t5_data", data_out, 8'h81);
        check("t5_valid", data_valid, 1);
        check("t5_ferr", ferr_hi - f0, 0);
        ack_once;

`ifdef SPI_RX_TIMEOUT_EN
        f0 = ferr_hi;
        spi_cs = 1'b0;
        wait_clk(5);
        send_bits(8'hFF, 3);
        wait_clk(200);
        check("t6_ferr", ferr_hi - f0, 1);
        check("t6_busy", busy, 0);
        wait_clk(100);
        check("t6_hold", busy, 0);
        spi_cs = 1'b1;
        wait_clk(5);
        spi_cs = 1'b0;
        wait_clk(5);
        check("t6_reenter", busy, 1);
        spi_cs = 1'b1;
        wait_clk(10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
